// File: rtl/program_feeder_pkg.sv
// program_feeder shared types: sequencer states and instruction field layout.
package program_feeder_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_CAP,
        S_CAP_IMM,
        S_EXEC,
        S_HALT
    } state_e;

    localparam logic [2:0] OP_MVI = 3'b001;
    localparam int         OP_HI  = 15;
    localparam int         OP_LO  = 13;

    function automatic logic is_mvi(input logic [15:0] w);
        return w[OP_HI:OP_LO] == OP_MVI;
    endfunction

endpackage

// File: rtl/feeder_wdog.sv
// Per-instruction watchdog: loadable, clearable up-counter with terminal flag.
module feeder_wdog #(
    parameter int TIMEOUT = 16,
    parameter int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clr_i,
    input  logic          load_i,
    input  logic [CW-1:0] load_val_i,
    input  logic          inc_i,
    output logic          term_o
);

    logic [CW-1:0] cnt_q, cnt_d;

    assign term_o = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (inc_i && !term_o) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/program_feeder.sv
// Fetch sequencer feeding a 16-bit bus processor from a synchronous ROM,
// with per-instruction watchdog and program-end bound.
module program_feeder
    import program_feeder_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              Start,
    input  logic              Stop,
    input  logic [ADDR_W-1:0] end_addr,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [15:0]       mem_data,
    output logic [15:0]       DIN,
    output logic              Run,
    input  logic              Done,
    output logic [ADDR_W-1:0] pc,
    output logic              Busy,
    output logic              Error
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       din_q, din_d;
    logic [15:0]       instr_q, instr_d;
    logic [15:0]       imm_q, imm_d;
    logic              err_q, err_d;
    logic              stop_q, stop_d;
    logic [ADDR_W-1:0] pc_nxt;
    logic              mvi_q;
    logic              wd_term;

    assign mvi_q  = is_mvi(instr_q);
    assign pc_nxt = pc_q + (mvi_q ? ADDR_W'(2) : ADDR_W'(1));

    assign Run      = (state_q == S_EXEC);
    assign Busy     = (state_q != S_IDLE) && (state_q != S_HALT);
    assign DIN      = din_q;
    assign pc       = pc_q;
    assign mem_addr = addr_q;
    assign Error    = err_q;

    feeder_wdog #(
        .TIMEOUT (TIMEOUT),
        .CW      (CW)
    ) u_wdog (
        .clk_i      (Clock),
        .rst_ni     (Resetn),
        .clr_i      (!Run || Done),
        .load_i     (1'b0),
        .load_val_i ('0),
        .inc_i      (Run),
        .term_o     (wd_term)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        din_d   = din_q;
        instr_d = instr_q;
        imm_d   = imm_q;
        err_d   = err_q;
        stop_d  = stop_q;
        unique case (state_q)
            S_IDLE: begin
                if (Start && !Stop) begin
                    state_d = S_FETCH;
                    addr_d  = pc_q;
                end
            end
            S_FETCH: begin
                state_d = S_CAP;
                addr_d  = pc_q + ADDR_W'(1);
            end
            S_CAP: begin
                instr_d = mem_data;
                if (is_mvi(mem_data)) begin
                    state_d = S_CAP_IMM;
                end else begin
                    din_d   = mem_data;
                    state_d = S_EXEC;
                end
            end
            S_CAP_IMM: begin
                imm_d   = mem_data;
                din_d   = instr_q;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // Done beats a watchdog expiry in the same cycle
                if (Done) begin
                    pc_d = pc_nxt;
                    if (stop_q || Stop || pc_q >= end_addr
                        || pc_nxt > end_addr) begin
                        state_d = S_HALT;
                    end else begin
                        state_d = S_FETCH;
                        addr_d  = pc_nxt;
                    end
                end else if (wd_term) begin
                    err_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    din_d = mvi_q ? imm_q : instr_q;
                end
            end
            S_HALT: begin
                if (Start && !err_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (Stop && Busy) begin
            stop_d = 1'b1;
        end
        if (state_d == S_FETCH) begin
            stop_d = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            instr_q <= '0;
            imm_q   <= '0;
            err_q   <= 1'b0;
            stop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            instr_q <= instr_d;
            imm_q   <= imm_d;
            err_q   <= err_d;
            stop_q  <= stop_d;
        end
    end

endmodule

// File: doc/program_feeder.md
# program_feeder

Sequencer that sits directly upstream of the 16-bit bus processor: it walks a program counter through a synchronous instruction ROM, fetches each instruction word (and, for `mvi`, the following immediate word), presents it on the processor's `DIN`, and holds `Run` until the processor answers with `Done`. It includes a per-instruction watchdog and a program-end bound so a stuck or finished program stops cleanly.

## Interface
- `ADDR_W`, 8: ROM address width; `pc` wraps modulo 2^ADDR_W.
- `TIMEOUT`, 16: maximum EXEC cycles without `Done` before `Error`.

- `Clock`  in  1  single clock, all state on rising edge
- `Resetn`  in  1  asynchronous, active-low reset
- `Start`  in  1  level; sampled in IDLE to begin execution at `pc`
- `Stop`  in  1  request halt after the current instruction completes
- `end_addr`  in  ADDR_W  last valid program address (inclusive)
- `mem_addr`  out  ADDR_W  ROM address
- `mem_data`  in  16  ROM word, valid the cycle after `mem_addr` is driven
- `DIN`  out  16  word presented to the processor
- `Run`  out  1  instruction in flight
- `Done`  in  1  processor completion, sampled only in EXEC
- `pc`  out  ADDR_W  address of current instruction
- `Busy`  out  1  high in any state but IDLE and HALT
- `Error`  out  1  sticky watchdog flag

## Operation
- Word format: opcode = word[15:13]; `mvi` = 3'b001 is the only two-word instruction.
- States: IDLE, FETCH, CAP, CAP_IMM, EXEC, HALT.
- IDLE: `Start`=1 -> FETCH.
- FETCH: `mem_addr`=pc -> CAP.
- CAP: capture `mem_data` into instr reg; drive `mem_addr`=pc+1 (wraps); opcode `mvi` -> CAP_IMM, else -> EXEC.
- CAP_IMM: capture `mem_data` into imm reg -> EXEC.
- EXEC: `Run`=1. First EXEC cycle `DIN`=instr; later cycles `DIN`=imm for `mvi`, instr otherwise. Watchdog counts EXEC cycles.
  - `Done`=1: pc += 2 (`mvi`) or 1, modulo 2^ADDR_W; watchdog clears; then HALT if `Stop` was seen since entering FETCH, or if old pc ≥ `end_addr` or the new pc would exceed `end_addr`; otherwise FETCH.
  - Watchdog reaches `TIMEOUT` with no `Done`: `Error`=1, HALT, pc unchanged.
- HALT: `Run`=0. `Start`=1 with `Error`=0 -> IDLE, keeping pc; `Error` clears only on reset.
- `Stop` in IDLE keeps the block in IDLE; in HALT it has no effect.

## Timing
- Reset, asynchronous: state IDLE; pc, `mem_addr`, `DIN`, instr, imm and watchdog all 0; `Run`, `Busy` and `Error` 0.
- Non-`mvi`: `Start` sampled at edge k -> FETCH k+1, CAP k+2, `Run` rises at k+3.
- `mvi`: `Run` rises at k+4, and `DIN` = imm from the second EXEC cycle.
- `Run` falls the edge after `Done` is sampled. Next `Run` rises 3 (or 4) cycles later.
- `DIN` is registered and stable throughout each EXEC cycle.
- `Done` outside EXEC is ignored.
- `Done` in the same cycle the watchdog expires: `Done` wins, no `Error`.
- A `mvi` at address 2^ADDR_W−1 fetches its immediate from address 0.
- Reset mid-EXEC: `Run` drops immediately, with no pc advance.

## Structure
- `program_feeder_pkg`: state enum, `OP_MVI`=3'b001, opcode field bounds [15:13].
- One sub-module, `feeder_wdog`: a loadable, clearable up-counter with a terminal flag, parameterised by `TIMEOUT`.
- The ROM stays external; the bench models it with one cycle of latency.

## Test plan
- Program {0x0000 (mv), 0x4400 (add)}, `end_addr`=1, `Done` two cycles after each `Run` rise -> two `Run` pulses with `DIN` 0x0000 then 0x4400; pc ends at 2; HALT with `Busy`=0.
- Word 0x2000 (`mvi`) at 3, word 0x00A5 at 4 -> first EXEC cycle `DIN`=0x2000, then 0x00A5; pc moves 3 -> 5.
- `Done` held low -> `Error` rises after exactly 16 EXEC cycles; pc unchanged; a later `Start` does not leave HALT.
- `Stop` pulsed during EXEC of instruction 0 of 4 -> HALT after `Done` with pc=1; `Start` -> IDLE, then resumes at 1.
- `ADDR_W`=4, `mvi` at 0xF, `end_addr`=0xF -> immediate read from `mem_addr`=0; pc wraps to 1; HALT.
- `Resetn` low mid-EXEC -> `Run`, `DIN`, pc and `Error` read 0 in the same cycle; state returns to IDLE.
